// File: rtl/vram_tile_fill.sv
// Tile-map video RAM for a 20x15 tile display: CPU port, display port
// and a rectangle-fill engine that shares the single write port.
module vram_tile_fill #(
    parameter int COLS  = 20,
    parameter int ROWS  = 15,
    parameter int DEPTH = 300,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          fill_start,
    input  logic [4:0]    fill_col0,
    input  logic [3:0]    fill_row0,
    input  logic [4:0]    fill_col1,
    input  logic [3:0]    fill_row1,
    input  logic [5:0]    fill_color,
    output logic          fill_busy,
    output logic          fill_done,
    input  logic [AW-1:0] vaddr,
    output logic [DW-1:0] vdata
);

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW-1:0] COLS_A  = AW'(COLS);
    localparam logic [4:0]    CMAX    = 5'(COLS - 1);
    localparam logic [3:0]    RMAX    = 4'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    logic [DW-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [4:0]    col0_q, col0_d;
    logic [4:0]    col1_q, col1_d;
    logic [3:0]    row0_q, row0_d;
    logic [3:0]    row1_q, row1_d;
    logic [5:0]    color_q, color_d;
    logic [4:0]    cur_col_q, cur_col_d;
    logic [3:0]    cur_row_q, cur_row_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [DW-1:0] cpu_rdata_q, vdata_q;

    logic [4:0]    col1_clamp;
    logic [3:0]    row1_clamp;
    logic          rect_empty;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] row_step;
    logic          fill_we;
    logic          cpu_wr_ok;

    // Clamp the far corner to the screen; an inverted or off-screen
    // origin produces an empty rectangle.
    assign col1_clamp = (fill_col1 > CMAX) ? CMAX : fill_col1;
    assign row1_clamp = (fill_row1 > RMAX) ? RMAX : fill_row1;
    assign rect_empty = (fill_col0 > col1_clamp) || (fill_row0 > row1_clamp);
    assign start_addr = AW'(fill_col0)
                      + (AW'(fill_row0) << 4)
                      + (AW'(fill_row0) << 2);
    assign row_step   = COLS_A - AW'(col1_q) + AW'(col0_q);
    assign cpu_wr_ok  = cpu_we && (cpu_addr < DEPTH_A);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            col0_q     <= '0;
            col1_q     <= '0;
            row0_q     <= '0;
            row1_q     <= '0;
            color_q    <= '0;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
            cur_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            col0_q     <= col0_d;
            col1_q     <= col1_d;
            row0_q     <= row0_d;
            row1_q     <= row1_d;
            color_q    <= color_d;
            cur_col_q  <= cur_col_d;
            cur_row_q  <= cur_row_d;
            cur_addr_q <= cur_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col0_d     = col0_q;
        col1_d     = col1_q;
        row0_d     = row0_q;
        row1_d     = row1_q;
        color_d    = color_q;
        cur_col_d  = cur_col_q;
        cur_row_d  = cur_row_q;
        cur_addr_d = cur_addr_q;
        unique case (state_q)
            IDLE: begin
                if (fill_start) begin
                    col0_d     = fill_col0;
                    row0_d     = fill_row0;
                    col1_d     = col1_clamp;
                    row1_d     = row1_clamp;
                    color_d    = fill_color;
                    cur_col_d  = fill_col0;
                    cur_row_d  = fill_row0;
                    cur_addr_d = start_addr;
                    state_d    = rect_empty ? DONE : FILL;
                end
            end
            FILL: begin
                // Any CPU write strobe stalls the engine for that cycle.
                if (!cpu_we) begin
                    if (cur_col_q == col1_q && cur_row_q == row1_q) begin
                        state_d = DONE;
                    end else if (cur_col_q == col1_q) begin
                        cur_col_d  = col0_q;
                        cur_row_d  = cur_row_q + 4'd1;
                        cur_addr_d = cur_addr_q + row_step;
                    end else begin
                        cur_col_d  = cur_col_q + 5'd1;
                        cur_addr_d = cur_addr_q + AW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        fill_busy = (state_q != IDLE);
        fill_done = (state_q == DONE);
        fill_we   = (state_q == FILL) && !cpu_we;
    end

    always_ff @(posedge clk) begin
        if (cpu_wr_ok) begin
            mem[cpu_addr] <= cpu_wdata;
        end else if (fill_we) begin
            mem[cur_addr_q] <= {{(DW-6){1'b0}}, color_q};
        end
    end

    // Reads return the pre-write contents on a same-cycle collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata_q <= '0;
            vdata_q     <= '0;
        end else begin
            cpu_rdata_q <= (cpu_addr < DEPTH_A) ? mem[cpu_addr] : '0;
            vdata_q     <= (vaddr < DEPTH_A) ? mem[vaddr] : '0;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign vdata     = vdata_q;

endmodule

// File: tb/tb_vram_tile_fill.sv
// Directed bench for vram_tile_fill: CPU/display reads, fills, stalls,
// clamping, out-of-range access, collisions and reset during a fill.
module tb_vram_tile_fill;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        fill_start;
    logic [4:0]  fill_col0;
    logic [3:0]  fill_row0;
    logic [4:0]  fill_col1;
    logic [3:0]  fill_row1;
    logic [5:0]  fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic [8:0]  vaddr;
    logic [31:0] vdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_mem [300];

    vram_tile_fill dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .fill_start (fill_start),
        .fill_col0  (fill_col0),
        .fill_row0  (fill_row0),
        .fill_col1  (fill_col1),
        .fill_row1  (fill_row1),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .vaddr      (vaddr),
        .vdata      (vdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
        cpu_we    = 1'b0;
    endtask

    task automatic rd(input logic [8:0] a, output logic [31:0] d);
        cpu_addr = a;
        tick();
        d = cpu_rdata;
    endtask

    task automatic start_fill(input logic [4:0] c0, input logic [3:0] r0,
                              input logic [4:0] c1, input logic [3:0] r1,
                              input logic [5:0] col);
        fill_col0  = c0;
        fill_row0  = r0;
        fill_col1  = c1;
        fill_row1  = r1;
        fill_color = col;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        fill_col0  = 5'd0;
        fill_row0  = 4'd0;
        fill_col1  = 5'd0;
        fill_row1  = 4'd0;
        fill_color = 6'd0;
    endtask

    // Counts busy cycles and done pulses until idle, bounded.
    task automatic wait_idle(output int busy_cyc, output int dones);
        busy_cyc = 0;
        dones    = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!fill_busy) break;
            busy_cyc++;
            if (fill_done) dones++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        fill_start = 1'b0;
        fill_col0  = '0;
        fill_row0  = '0;
        fill_col1  = '0;
        fill_row1  = '0;
        fill_color = '0;
        vaddr      = '0;
        tick();
        tick();
        checks++;
        if (cpu_rdata !== 32'd0 || vdata !== 32'd0 ||
            fill_busy !== 1'b0 || fill_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdata=%h vdata=%h busy=%b done=%b want 0",
                     cpu_rdata, vdata, fill_busy, fill_done);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_cpu_rw();
        logic [31:0] d;
        wr(9'd0, 32'h2A);
        wr(9'd299, 32'h15);
        exp_mem[0]   = 32'h2A;
        exp_mem[299] = 32'h15;
        rd(9'd0, d);
        checks++;
        if (d !== 32'h2A) begin
            errors++;
            $display("FAIL cpu_rd0: got %h want 0000002a", d);
        end
        rd(9'd299, d);
        checks++;
        if (d !== 32'h15) begin
            errors++;
            $display("FAIL cpu_rd299: got %h want 00000015", d);
        end
        vaddr = 9'd0;
        tick();
        vaddr = 9'd299;
        #1;
        checks++;
        if (vdata !== 32'h2A) begin
            errors++;
            $display("FAIL vdata_latency: got %h want 0000002a", vdata);
        end
        tick();
        checks++;
        if (vdata !== 32'h15) begin
            errors++;
            $display("FAIL vdata299: got %h want 00000015", vdata);
        end
    endtask

    task automatic test_full_fill();
        int cyc, dn, bad;
        logic [31:0] d;
        start_fill(5'd0, 4'd0, 5'd19, 4'd14, 6'h30);
        wait_idle(cyc, dn);
        checks++;
        if (cyc != 301 || dn != 1) begin
            errors++;
            $display("FAIL full_fill_timing: busy=%0d done=%0d want 301 1",
                     cyc, dn);
        end
        for (int i = 0; i < 300; i++) exp_mem[i] = 32'h30;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            rd(9'(i), d);
            if (d !== 32'h30) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_fill_data: %0d bad words want 0", bad);
        end
    endtask

    task automatic test_sub_fill();
        int cyc, dn;
        logic [31:0] d;
        start_fill(5'd3, 4'd2, 5'd5, 4'd4, 6'h0C);
        wait_idle(cyc, dn);
        checks++;
        if (cyc != 10 || dn != 1) begin
            errors++;
            $display("FAIL sub_fill_timing: busy=%0d done=%0d want 10 1",
                     cyc, dn);
        end
        for (int r = 2; r <= 4; r++)
            for (int c = 3; c <= 5; c++)
                exp_mem[c + r * 20] = 32'h0C;
        for (int i = 40; i < 90; i++) begin
            rd(9'(i), d);
            checks++;
            if (d !== exp_mem[i]) begin
                errors++;
                $display("FAIL sub_fill_addr%0d: got %h want %h",
                         i, d, exp_mem[i]);
            end
        end
    endtask

    task automatic test_stall();
        int cyc, dn, pre;
        logic [31:0] d;
        start_fill(5'd0, 4'd5, 5'd3, 4'd5, 6'h3F);
        pre = 0;
        for (int i = 0; i < 3; i++) begin
            if (fill_busy) pre++;
            cpu_we    = 1'b1;
            cpu_addr  = 9'(200 + i);
            cpu_wdata = 32'hA000_0000 + 32'(i);
            tick();
        end
        cpu_we = 1'b0;
        wait_idle(cyc, dn);
        checks++;
        if (pre + cyc != 8 || dn != 1) begin
            errors++;
            $display("FAIL stall_timing: busy=%0d done=%0d want 8 1",
                     pre + cyc, dn);
        end
        for (int i = 100; i < 104; i++) exp_mem[i] = 32'h3F;
        for (int i = 0; i < 3; i++) exp_mem[200 + i] = 32'hA000_0000 + 32'(i);
        for (int i = 99; i < 105; i++) begin
            rd(9'(i), d);
            checks++;
            if (d !== exp_mem[i]) begin
                errors++;
                $display("FAIL stall_fill_addr%0d: got %h want %h",
                         i, d, exp_mem[i]);
            end
        end
        for (int i = 199; i < 204; i++) begin
            rd(9'(i), d);
            checks++;
            if (d !== exp_mem[i]) begin
                errors++;
                $display("FAIL stall_cpu_addr%0d: got %h want %h",
                         i, d, exp_mem[i]);
            end
        end
    endtask

    task automatic test_clamp();
        int cyc, dn;
        logic [31:0] d;
        logic [8:0] addrs [6];
        addrs = '{9'd277, 9'd278, 9'd279, 9'd297, 9'd298, 9'd299};
        start_fill(5'd18, 4'd13, 5'd31, 4'd15, 6'h01);
        wait_idle(cyc, dn);
        checks++;
        if (cyc != 5 || dn != 1) begin
            errors++;
            $display("FAIL clamp_timing: busy=%0d done=%0d want 5 1", cyc, dn);
        end
        exp_mem[278] = 32'h01;
        exp_mem[279] = 32'h01;
        exp_mem[298] = 32'h01;
        exp_mem[299] = 32'h01;
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i], d);
            checks++;
            if (d !== exp_mem[addrs[i]]) begin
                errors++;
                $display("FAIL clamp_addr%0d: got %h want %h",
                         addrs[i], d, exp_mem[addrs[i]]);
            end
        end
    endtask

    task automatic test_empty();
        logic [31:0] d;
        start_fill(5'd10, 4'd0, 5'd5, 4'd0, 6'h2A);
        checks++;
        if (fill_done !== 1'b1 || fill_busy !== 1'b1) begin
            errors++;
            $display("FAIL empty_done: done=%b busy=%b want 1 1",
                     fill_done, fill_busy);
        end
        fill_start = 1'b1;
        fill_col0  = 5'd0;
        fill_col1  = 5'd0;
        fill_color = 6'h2A;
        tick();
        fill_start = 1'b0;
        checks++;
        if (fill_done !== 1'b0 || fill_busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_idle: done=%b busy=%b want 0 0",
                     fill_done, fill_busy);
        end
        start_fill(5'd25, 4'd0, 5'd31, 4'd0, 6'h2A);
        checks++;
        if (fill_done !== 1'b1) begin
            errors++;
            $display("FAIL offscreen_done: done=%b want 1", fill_done);
        end
        tick();
        for (int i = 5; i <= 10; i++) begin
            rd(9'(i), d);
            checks++;
            if (d !== exp_mem[i]) begin
                errors++;
                $display("FAIL empty_addr%0d: got %h want %h",
                         i, d, exp_mem[i]);
            end
        end
        rd(9'd0, d);
        checks++;
        if (d !== exp_mem[0]) begin
            errors++;
            $display("FAIL ignored_start_addr0: got %h want %h", d, exp_mem[0]);
        end
    endtask

    task automatic test_oob();
        logic [31:0] d;
        wr(9'd300, 32'hDEAD_BEEF);
        wr(9'd511, 32'hCAFE_F00D);
        rd(9'd300, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL oob_cpu_rd: got %h want 00000000", d);
        end
        vaddr = 9'd300;
        tick();
        checks++;
        if (vdata !== 32'd0) begin
            errors++;
            $display("FAIL oob_vdata: got %h want 00000000", vdata);
        end
        for (int i = 0; i < 300; i += 44) begin
            rd(9'(i), d);
            checks++;
            if (d !== exp_mem[i]) begin
                errors++;
                $display("FAIL oob_alias_addr%0d: got %h want %h",
                         i, d, exp_mem[i]);
            end
        end
    endtask

    task automatic test_same_addr();
        vaddr     = 9'd50;
        cpu_we    = 1'b1;
        cpu_addr  = 9'd50;
        cpu_wdata = 32'h1234_5678;
        tick();
        cpu_we = 1'b0;
        checks++;
        if (vdata !== exp_mem[50] || cpu_rdata !== exp_mem[50]) begin
            errors++;
            $display("FAIL same_addr_old: vdata=%h rdata=%h want %h",
                     vdata, cpu_rdata, exp_mem[50]);
        end
        exp_mem[50] = 32'h1234_5678;
        tick();
        checks++;
        if (vdata !== 32'h1234_5678 || cpu_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL same_addr_new: vdata=%h rdata=%h want 12345678",
                     vdata, cpu_rdata);
        end
    endtask

    task automatic test_reset_mid_fill();
        int cyc, dn, seen;
        logic [31:0] d;
        start_fill(5'd0, 4'd0, 5'd19, 4'd14, 6'h2B);
        for (int i = 0; i < 5; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (fill_busy !== 1'b0 || fill_done !== 1'b0 ||
            cpu_rdata !== 32'd0 || vdata !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b rdata=%h vdata=%h want 0",
                     fill_busy, fill_done, cpu_rdata, vdata);
        end
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (fill_done || fill_busy) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: %0d active cycles want 0", seen);
        end
        start_fill(5'd0, 4'd0, 5'd0, 4'd0, 6'h07);
        wait_idle(cyc, dn);
        checks++;
        if (cyc != 2 || dn != 1) begin
            errors++;
            $display("FAIL post_reset_fill: busy=%0d done=%0d want 2 1",
                     cyc, dn);
        end
        rd(9'd0, d);
        checks++;
        if (d !== 32'h07) begin
            errors++;
            $display("FAIL post_reset_data: got %h want 00000007", d);
        end
        rd(9'd299, d);
        checks++;
        if (d !== exp_mem[299]) begin
            errors++;
            $display("FAIL post_reset_keep299: got %h want %h",
                     d, exp_mem[299]);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_full_fill();
        test_sub_fill();
        test_stall();
        test_clamp();
        test_empty();
        test_oob();
        test_same_addr();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
